scariv_inst_buffer: RTL and testbench
=====================================

// Module: scariv_inst_buffer
// PURPOSE
//  Decouples I-cache fetch from decode/dispatch. Accepts one ICACHE_DATA_W fetch line per cycle
//  (ICACHE_DATA_W/32 RV32 words) into a ring of INST_BUF_SIZE line entries.
//  Issues up to DISP_SIZE consecutive instructions per cycle, in program order, to the dispatch stage.
// PARAMETERS
//  ICACHE_DATA_W  128  fetch line width; W = ICACHE_DATA_W/32 words per line (default 4)
//  INST_BUF_SIZE  6    line entries in the ring
//  DISP_SIZE      2    max instructions issued per cycle
//  VADDR_W        39   virtual PC width
// PORTS
//  i_clk              in   1              clock
//  i_reset            in   1              asynchronous, active-high reset
//  i_flush            in   1              pipeline redirect: empty buffer
//  i_fetch_valid      in   1              fetch line valid
//  o_fetch_ready      out  1              buffer can accept a line this cycle
//  i_fetch_pc         in   VADDR_W        line-aligned PC (low log2(ICACHE_DATA_W/8) bits zero)
//  i_fetch_data       in   ICACHE_DATA_W  line data, word 0 in bits [31:0]
//  i_fetch_start_idx  in   log2(W)        first valid word (branch-target entry)
//  i_fetch_taken      in   1              predictor: line ends at a taken branch
//  i_fetch_taken_idx  in   log2(W)        word index of that taken branch
//  o_disp_valid       out  1              >=1 instruction offered
//  i_disp_ready       in   1              dispatch accepts the whole group
//  o_disp_inst_valid  out  DISP_SIZE      per-slot valid, contiguous from slot 0
//  o_disp_inst        out  DISP_SIZE*32   instruction words
//  o_disp_pc          out  DISP_SIZE*VADDR_W  per-slot PC
//  o_disp_pred_taken  out  DISP_SIZE      slot holds the predicted-taken branch
// BEHAVIOUR
//  - Reset (async): head/tail pointers 0, count 0, word pointer 0, all entry valid bits 0.
//    o_disp_valid=0, o_disp_inst_valid=0, o_fetch_ready=1 once reset deasserts.
//  - o_fetch_ready = (count < INST_BUF_SIZE), from registered count only.
//    No path from i_disp_ready to o_fetch_ready.
//    Enqueue when i_fetch_valid & o_fetch_ready & ~i_flush.
//    Entry stores pc, data, start, end = taken ? taken_idx : W-1, and the taken flag.
//    taken_idx < start_idx is illegal (assertion).
//  - Word pointer wp starts at the head entry's start.
//    Group = up to DISP_SIZE words from wp to head.end, then from head+1.start onward
//    only if head.taken=0 and entry head+1 is valid. Never spans more than 2 entries.
//  - The group is truncated after any slot whose pred_taken=1.
//    The rest of that entry is discarded (end already excludes it).
//  - Slot PC = entry.pc + 4*word_idx (VADDR_W wrap, no carry out).
//  - Outputs are combinational from registered state (0-cycle read).
//    Enqueue-to-visible latency is 1 cycle; no bypass of an empty buffer.
//  - Handshake: fire = o_disp_valid & i_disp_ready.
//    On fire all offered slots are consumed; partial acceptance does not exist.
//    Offered outputs stay stable while o_disp_valid & ~i_disp_ready.
//  - On fire, an entry is freed when its last word (end) is consumed; 0, 1 or 2 entries per cycle.
//    head advances modulo INST_BUF_SIZE.
//    wp = next entry's start, or wp+n within the same entry.
//  - Same-cycle enqueue + free: count += 1 - freed. Count is never above INST_BUF_SIZE.
//    When full, a free this cycle does not raise ready until the next cycle.
//  - i_flush: has priority over enqueue and dispatch in the same cycle.
//    Next cycle count=0, pointers=0, o_disp_valid=0.
//    A fire coinciding with flush is still a valid handoff; dispatch must drop it.
//  - Reset asserted mid-operation: immediate return to the reset state; in-flight lines are lost.
// STRUCTURE
//  - Shared package (scariv_pkg): typedef ibuf_entry_t {pc, data, start, end, taken}
//    and typedef disp_slot_t {inst, pc, pred_taken}.
//    Derived constant IBUF_WORDS = ICACHE_DATA_W/32.
//  - Sub-module scariv_ibuf_ring_ptr: modulo-N pointer with increment of 0/1/2
//    and a clear input; instantiated for head and tail.
// TESTING
//  1 Reset, then one line at pc=0x1000, start=0, taken=0, ready=1
//    -> groups {0x1000,0x1004}, {0x1008,0x100C}; entry freed; count back to 0.
//  2 Line start=3 at pc=0x2000, next line pc=0x2010 start=0
//    -> one group {0x200C,0x2010} spanning two entries; first entry freed.
//  3 Line pc=0x3000, start=0, taken=1, taken_idx=0
//    -> a single slot 0x3000 with pred_taken=1, slot1 invalid; words 1..3 never issued.
//  4 Hold i_disp_ready=0 and push 6 lines -> o_fetch_ready=0 after 6 accepts; the 7th line is held.
//    Raise ready with a 7th line pending -> the 7th is accepted one cycle after the first free.
//  5 Buffer at 4 entries, i_flush with i_fetch_valid=1 -> next cycle o_disp_valid=0, count=0.
//    The flush-cycle line is not stored.
//  6 Assert i_reset asynchronously mid-group with ready stalled
//    -> o_disp_valid falls without a clock edge; after reset o_fetch_ready=1.

Source files
------------

// File: rtl/scariv_pkg.sv
// Shared types and constants for the instruction buffer: fetch-line entry,
// dispatch slot, and the word-PC helper.
package scariv_pkg;

  localparam int ICACHE_DATA_W = 128;
  localparam int IBUF_WORDS    = ICACHE_DATA_W / 32;
  localparam int WIDX_W        = $clog2(IBUF_WORDS);
  localparam int INST_BUF_SIZE = 6;
  localparam int DISP_SIZE     = 2;
  localparam int VADDR_W       = 39;

  typedef struct packed {
    logic [VADDR_W-1:0]       pc;
    logic [ICACHE_DATA_W-1:0] data;
    logic [WIDX_W-1:0]        start_idx;
    logic [WIDX_W-1:0]        end_idx;
    logic                     taken;
  } ibuf_entry_t;

  typedef struct packed {
    logic [31:0]        inst;
    logic [VADDR_W-1:0] pc;
    logic               pred_taken;
  } disp_slot_t;

  function automatic logic [VADDR_W-1:0] word_pc(input logic [VADDR_W-1:0] line_pc,
                                                 input logic [WIDX_W-1:0]  idx);
    return line_pc + VADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/scariv_ibuf_ring_ptr.sv
// Modulo-N ring pointer advancing by 0, 1 or 2 per cycle, with a synchronous clear.
module scariv_ibuf_ring_ptr #(
  parameter int N     = 6,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic [1:0]       i_inc,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_next;
  logic [PTR_W-1:0] r_ptr;

  // wrap-around add
  always_comb begin
    w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i_inc);
    if (w_sum >= (PTR_W+1)'(N)) begin
      w_next = PTR_W'(w_sum - (PTR_W+1)'(N));
    end else begin
      w_next = w_sum[PTR_W-1:0];
    end
  end

  // pointer register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/scariv_inst_buffer.sv
// Instruction buffer between I-cache fetch and dispatch: a ring of fetch lines
// issuing up to DISP_SIZE program-ordered instructions per cycle.
module scariv_inst_buffer
  import scariv_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic                         i_fetch_valid,
  output logic                         o_fetch_ready,
  input  logic [VADDR_W-1:0]           i_fetch_pc,
  input  logic [ICACHE_DATA_W-1:0]     i_fetch_data,
  input  logic [WIDX_W-1:0]            i_fetch_start_idx,
  input  logic                         i_fetch_taken,
  input  logic [WIDX_W-1:0]            i_fetch_taken_idx,
  output logic                         o_disp_valid,
  input  logic                         i_disp_ready,
  output logic [DISP_SIZE-1:0]         o_disp_inst_valid,
  output logic [DISP_SIZE*32-1:0]      o_disp_inst,
  output logic [DISP_SIZE*VADDR_W-1:0] o_disp_pc,
  output logic [DISP_SIZE-1:0]         o_disp_pred_taken
);

  localparam int PTR_W = $clog2(INST_BUF_SIZE);
  localparam int CNT_W = $clog2(INST_BUF_SIZE + 1);

  ibuf_entry_t              r_entries [INST_BUF_SIZE];
  logic [INST_BUF_SIZE-1:0] r_valid;
  logic [CNT_W-1:0]         r_count;

  logic [PTR_W-1:0]         w_head;
  logic [PTR_W-1:0]         w_tail;
  logic [PTR_W-1:0]         w_next_idx;
  ibuf_entry_t              w_head_e;
  ibuf_entry_t              w_next_e;
  ibuf_entry_t              w_enq_e;
  disp_slot_t               w_slot [DISP_SIZE];
  logic [DISP_SIZE-1:0]     w_slot_vld;
  logic                     w_head_done;
  logic                     w_next_done;
  logic                     w_used_next;
  logic [WIDX_W-1:0]        w_new_wp;
  logic                     w_enq;
  logic                     w_fire;
  logic [1:0]               w_free;
  logic [INST_BUF_SIZE-1:0] w_valid_nxt;

  assign o_fetch_ready = (r_count < CNT_W'(INST_BUF_SIZE));
  assign w_enq         = i_fetch_valid & o_fetch_ready & ~i_flush;
  assign w_fire        = o_disp_valid & i_disp_ready;
  assign w_free        = w_fire ? ({1'b0, w_head_done} + {1'b0, w_next_done}) : 2'd0;

  assign w_next_idx = (w_head == PTR_W'(INST_BUF_SIZE - 1)) ? '0 : w_head + PTR_W'(1);
  assign w_head_e   = r_entries[w_head];
  assign w_next_e   = r_entries[w_next_idx];

  assign w_enq_e.pc        = i_fetch_pc;
  assign w_enq_e.data      = i_fetch_data;
  assign w_enq_e.start_idx = i_fetch_start_idx;
  assign w_enq_e.end_idx   = i_fetch_taken ? i_fetch_taken_idx : WIDX_W'(IBUF_WORDS - 1);
  assign w_enq_e.taken     = i_fetch_taken;

  scariv_ibuf_ring_ptr #(.N(INST_BUF_SIZE), .PTR_W(PTR_W)) u_head_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_inc   (w_free),
    .o_ptr   (w_head)
  );

  scariv_ibuf_ring_ptr #(.N(INST_BUF_SIZE), .PTR_W(PTR_W)) u_tail_ptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_inc   ({1'b0, w_enq}),
    .o_ptr   (w_tail)
  );

  // Walk words from the head's word pointer; the head entry's start field
  // doubles as the word pointer, so a partial consume just rewrites it.
  always_comb begin : p_group
    logic              sel;
    logic              alive;
    logic [WIDX_W-1:0] widx;
    ibuf_entry_t       e;
    sel         = 1'b0;
    alive       = r_valid[w_head];
    widx        = w_head_e.start_idx;
    e           = w_head_e;
    w_head_done = 1'b0;
    w_next_done = 1'b0;
    w_used_next = 1'b0;
    for (int s = 0; s < DISP_SIZE; s++) begin
      e                    = sel ? w_next_e : w_head_e;
      w_slot_vld[s]        = alive;
      w_slot[s].inst       = e.data[{widx, 5'b00000} +: 32];
      w_slot[s].pc         = word_pc(e.pc, widx);
      w_slot[s].pred_taken = alive & e.taken & (widx == e.end_idx);
      if (alive && (widx == e.end_idx)) begin
        if (sel) begin
          w_next_done = 1'b1;
        end else begin
          w_head_done = 1'b1;
        end
        if (!sel && !e.taken && r_valid[w_next_idx]) begin
          sel         = 1'b1;
          widx        = w_next_e.start_idx;
          w_used_next = 1'b1;
        end else begin
          alive = 1'b0;
        end
      end else if (alive) begin
        widx = widx + WIDX_W'(1);
      end else begin
        widx = widx;
      end
    end
    w_new_wp = widx;
  end

  // next valid-bit image
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_fire && w_head_done) begin
      w_valid_nxt[w_head] = 1'b0;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
    if (w_fire && w_next_done) begin
      w_valid_nxt[w_next_idx] = 1'b0;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
    if (w_enq) begin
      w_valid_nxt[w_tail] = 1'b1;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
  end

  // occupancy and valid bits
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_free);
    end
  end

  // line payload and word-pointer update (guarded by valid bits, so no reset)
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_entries[w_tail] <= w_enq_e;
    end
    if (w_fire && !i_flush) begin
      if (!w_head_done) begin
        r_entries[w_head].start_idx <= w_new_wp;
      end else if (w_used_next && !w_next_done) begin
        r_entries[w_next_idx].start_idx <= w_new_wp;
      end
    end
  end

  for (genvar g = 0; g < DISP_SIZE; g++) begin : g_out
    assign o_disp_inst_valid[g]             = w_slot_vld[g];
    assign o_disp_inst[g*32 +: 32]          = w_slot_vld[g] ? w_slot[g].inst : 32'h0;
    assign o_disp_pc[g*VADDR_W +: VADDR_W]  = w_slot_vld[g] ? w_slot[g].pc : {VADDR_W{1'b0}};
    assign o_disp_pred_taken[g]             = w_slot[g].pred_taken;
  end
  assign o_disp_valid = w_slot_vld[0];

  scariv_inst_buffer_chk u_chk (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_fetch_valid     (i_fetch_valid),
    .i_fetch_taken     (i_fetch_taken),
    .i_fetch_start_idx (i_fetch_start_idx),
    .i_fetch_taken_idx (i_fetch_taken_idx),
    .i_count           (r_count),
    .i_inst_valid      (o_disp_inst_valid)
  );

endmodule

// Protocol and invariant checks for the instruction buffer.
module scariv_inst_buffer_chk
  import scariv_pkg::*;
(
  input logic                                 i_clk,
  input logic                                 i_reset,
  input logic                                 i_fetch_valid,
  input logic                                 i_fetch_taken,
  input logic [WIDX_W-1:0]                    i_fetch_start_idx,
  input logic [WIDX_W-1:0]                    i_fetch_taken_idx,
  input logic [$clog2(INST_BUF_SIZE + 1)-1:0] i_count,
  input logic [DISP_SIZE-1:0]                 i_inst_valid
);

  a_taken_idx: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_fetch_valid && i_fetch_taken) |-> (i_fetch_taken_idx >= i_fetch_start_idx));

  a_count_max: assert property (@(posedge i_clk) disable iff (i_reset)
    i_count <= ($clog2(INST_BUF_SIZE + 1))'(INST_BUF_SIZE));

  a_slot0_first: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_inst_valid != '0) |-> i_inst_valid[0]);

endmodule

// File: tb/tb_scariv_inst_buffer.sv
// Directed bench for scariv_inst_buffer with a word-level scoreboard of issued instructions.
module tb_scariv_inst_buffer;
  import scariv_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         flush = 1'b0;
  logic                         fvalid = 1'b0;
  logic                         fready;
  logic [VADDR_W-1:0]           fpc = '0;
  logic [ICACHE_DATA_W-1:0]     fdata = '0;
  logic [1:0]                   fstart = 2'd0;
  logic                         ftaken = 1'b0;
  logic [1:0]                   ftidx = 2'd0;
  logic                         dvalid;
  logic                         dready = 1'b0;
  logic [DISP_SIZE-1:0]         divalid;
  logic [DISP_SIZE*32-1:0]      dinst;
  logic [DISP_SIZE*VADDR_W-1:0] dpc;
  logic [DISP_SIZE-1:0]         dpred;

  typedef struct {
    logic [31:0]        inst;
    logic [VADDR_W-1:0] pc;
    logic               pred;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;

  scariv_inst_buffer dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_flush           (flush),
    .i_fetch_valid     (fvalid),
    .o_fetch_ready     (fready),
    .i_fetch_pc        (fpc),
    .i_fetch_data      (fdata),
    .i_fetch_start_idx (fstart),
    .i_fetch_taken     (ftaken),
    .i_fetch_taken_idx (ftidx),
    .o_disp_valid      (dvalid),
    .i_disp_ready      (dready),
    .o_disp_inst_valid (divalid),
    .o_disp_inst       (dinst),
    .o_disp_pc         (dpc),
    .o_disp_pred_taken (dpred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [VADDR_W-1:0] pc);
    return {8'hA5, pc[23:0]};
  endfunction

  function automatic logic [ICACHE_DATA_W-1:0] mk_line(input logic [VADDR_W-1:0] pc);
    logic [ICACHE_DATA_W-1:0] l;
    l = '0;
    for (int k = 0; k < IBUF_WORDS; k++) l[k*32 +: 32] = word_of(pc + VADDR_W'(4*k));
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [VADDR_W-1:0] pc, input int st, input logic tk, input int ti);
    int   last;
    exp_t e;
    last = tk ? ti : IBUF_WORDS - 1;
    for (int k = st; k <= last; k++) begin
      e.pc   = pc + VADDR_W'(4*k);
      e.inst = word_of(e.pc);
      e.pred = tk && (k == last);
      sb.push_back(e);
    end
  endtask

  task automatic send_line(input logic [VADDR_W-1:0] pc, input int st, input logic tk, input int ti);
    int budget;
    budget = 0;
    fpc = pc; fdata = mk_line(pc); fstart = 2'(st); ftaken = tk; ftidx = 2'(ti); fvalid = 1'b1;
    while (!fready && budget < 50) begin
      tick();
      budget++;
    end
    check("fetch_ready_wait", 64'(budget < 50), 64'd1);
    tick();
    fvalid = 1'b0;
    push_exp(pc, st, tk, ti);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    dready = 1'b1;
    while ((sb.size() != 0 || dvalid) && budget < 100) begin
      tick();
      budget++;
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_idle", 64'(dvalid), 64'd0);
    dready = 1'b0;
  endtask

  // scoreboard: compare every offered slot on each fire
  always @(negedge clk) begin
    if (!rst && dvalid && dready) begin
      check("inst_valid_contig", 64'(divalid == 2'b01 || divalid == 2'b11), 64'd1);
      for (int s = 0; s < DISP_SIZE; s++) begin
        if (divalid[s]) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
          end else begin
            m_e = sb.pop_front();
            check("slot_inst", 64'(dinst[s*32 +: 32]), 64'(m_e.inst));
            check("slot_pc", 64'(dpc[s*VADDR_W +: VADDR_W]), 64'(m_e.pc));
            check("slot_pred", 64'(dpred[s]), 64'(m_e.pred));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #1;
    check("rst_disp_valid", 64'(dvalid), 64'd0);
    check("rst_inst_valid", 64'(divalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_fetch_ready", 64'(fready), 64'd1);

    // 1: single line, two full groups
    dready = 1'b1;
    send_line(39'h1000, 0, 1'b0, 0);
    check("t1_g0_ivalid", 64'(divalid), 64'h3);
    check("t1_g0_pc0", 64'(dpc[0 +: VADDR_W]), 64'h1000);
    check("t1_g0_pc1", 64'(dpc[VADDR_W +: VADDR_W]), 64'h1004);
    tick();
    check("t1_g1_pc0", 64'(dpc[0 +: VADDR_W]), 64'h1008);
    check("t1_g1_pc1", 64'(dpc[VADDR_W +: VADDR_W]), 64'h100C);
    tick();
    check("t1_empty_valid", 64'(dvalid), 64'd0);
    check("t1_empty_ready", 64'(fready), 64'd1);
    dready = 1'b0;

    // 2: group spanning two entries
    send_line(39'h2000, 3, 1'b0, 0);
    send_line(39'h2010, 0, 1'b0, 0);
    check("t2_ivalid", 64'(divalid), 64'h3);
    check("t2_pc0", 64'(dpc[0 +: VADDR_W]), 64'h200C);
    check("t2_pc1", 64'(dpc[VADDR_W +: VADDR_W]), 64'h2010);
    check("t2_inst0", 64'(dinst[31:0]), 64'(word_of(39'h200C)));
    check("t2_pred", 64'(dpred), 64'h0);
    dready = 1'b1;
    tick();
    check("t2_next_pc0", 64'(dpc[0 +: VADDR_W]), 64'h2014);
    check("t2_next_pc1", 64'(dpc[VADDR_W +: VADDR_W]), 64'h2018);
    drain();

    // 3: taken branch at word 0 truncates the group and the line
    send_line(39'h3000, 0, 1'b1, 0);
    check("t3_ivalid", 64'(divalid), 64'h1);
    check("t3_pred", 64'(dpred), 64'h1);
    check("t3_pc0", 64'(dpc[0 +: VADDR_W]), 64'h3000);
    dready = 1'b1;
    tick();
    check("t3_after_valid", 64'(dvalid), 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    dready = 1'b0;

    // 4: fill to capacity, 7th line held until a free
    for (int i = 0; i < INST_BUF_SIZE; i++) send_line(39'h4000 + VADDR_W'(16*i), 0, 1'b0, 0);
    check("t4_full_ready", 64'(fready), 64'd0);
    fpc = 39'h4060; fdata = mk_line(39'h4060); fstart = 2'd0; ftaken = 1'b0; ftidx = 2'd0;
    fvalid = 1'b1;
    tick();
    tick();
    check("t4_held_ready", 64'(fready), 64'd0);
    check("t4_stable_pc0", 64'(dpc[0 +: VADDR_W]), 64'h4000);
    dready = 1'b1;
    tick();
    check("t4_p1_ready", 64'(fready), 64'd0);
    tick();
    check("t4_p2_ready", 64'(fready), 64'd1);
    tick();
    fvalid = 1'b0;
    push_exp(39'h4060, 0, 1'b0, 0);
    check("t4_refill_ready", 64'(fready), 64'd0);
    drain();

    // 5: flush with a fetch in the same cycle
    for (int i = 0; i < 4; i++) send_line(39'h5000 + VADDR_W'(16*i), 0, 1'b0, 0);
    flush = 1'b1;
    fpc = 39'h5100; fdata = mk_line(39'h5100); fstart = 2'd0; ftaken = 1'b0; fvalid = 1'b1;
    tick();
    flush = 1'b0;
    fvalid = 1'b0;
    sb.delete();
    check("t5_flush_valid", 64'(dvalid), 64'd0);
    check("t5_flush_ready", 64'(fready), 64'd1);
    tick();
    check("t5_not_stored", 64'(dvalid), 64'd0);
    send_line(39'h5200, 1, 1'b0, 0);
    check("t5_post_pc0", 64'(dpc[0 +: VADDR_W]), 64'h5204);
    drain();

    // 6: asynchronous reset mid-group
    send_line(39'h6000, 0, 1'b0, 0);
    check("t6_pre_valid", 64'(dvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 64'(dvalid), 64'd0);
    check("t6_async_ivalid", 64'(divalid), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_post_ready", 64'(fready), 64'd1);
    check("t6_post_valid", 64'(dvalid), 64'd0);
    send_line(39'h7000, 2, 1'b1, 3);
    check("t6_tail_ivalid", 64'(divalid), 64'h3);
    check("t6_tail_pred", 64'(dpred), 64'h2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
